// File: rtl/fir_mc_filter_if.sv
// Request/result and coefficient-load bus of the multi-channel FIR engine.
// The master drives requests and coefficient writes; the slave is the filter engine.
interface fir_mc_filter_if #(
  parameter int NCH    = 2,
  parameter int TAPS   = 211,
  parameter int NBANK  = 4,
  parameter int DATA_W = 16,
  parameter int COEF_W = 32
);
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                     filt_start;
  logic [CH_W-1:0]          filt_chan;
  logic [BANK_W-1:0]        filt_select;
  logic signed [DATA_W-1:0] input_val;
  logic                     coef_wr_en;
  logic [BANK_W-1:0]        coef_wr_bank;
  logic [ADDR_W-1:0]        coef_wr_addr;
  logic signed [COEF_W-1:0] coef_wr_data;
  logic                     hist_clr;
  logic signed [DATA_W-1:0] filt_result;
  logic [CH_W-1:0]          filt_chan_o;
  logic                     filt_sat;
  logic                     filt_done;
  logic                     filt_busy;
  logic                     filt_drop;

  modport master (
    output filt_start, filt_chan, filt_select, input_val,
    output coef_wr_en, coef_wr_bank, coef_wr_addr, coef_wr_data, hist_clr,
    input  filt_result, filt_chan_o, filt_sat, filt_done, filt_busy, filt_drop
  );

  modport slave (
    input  filt_start, filt_chan, filt_select, input_val,
    input  coef_wr_en, coef_wr_bank, coef_wr_addr, coef_wr_data, hist_clr,
    output filt_result, filt_chan_o, filt_sat, filt_done, filt_busy, filt_drop
  );
endinterface

// File: rtl/fir_mc_filter.sv
// Multi-channel, multi-bank FIR engine: per-channel history rings convolved with a
// runtime-loadable coefficient bank by one time-shared multiply-accumulator.
module fir_mc_filter #(
  parameter int NCH       = 2,
  parameter int TAPS      = 211,
  parameter int NBANK     = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 30
) (
  input logic            clk,
  input logic            rst_n,
  fir_mc_filter_if.slave bus
);
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic [ADDR_W-1:0]     LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W:0] HALF     = (ACC_W+1)'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0] MAX_OUT  = (ACC_W+1)'((2**(DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_OUT  = -MAX_OUT - 1;

  typedef enum logic [2:0] {CLEAR, IDLE, LOAD, MAC, DRAIN, OUT} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        cnt;
  logic [ADDR_W-1:0]        head [NCH];
  logic [CH_W-1:0]          cur_chan;
  logic [BANK_W-1:0]        cur_bank;
  logic signed [DATA_W-1:0] cur_sample;

  logic signed [DATA_W-1:0] hist [NCH][TAPS];
  logic signed [COEF_W-1:0] coef [NBANK][TAPS];
  logic signed [DATA_W-1:0] rd_sample;
  logic signed [COEF_W-1:0] rd_coef;
  logic signed [PROD_W-1:0] prod;
  logic                     rd_vld;
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc;

  logic [ADDR_W-1:0]        cur_head;
  logic [ADDR_W-1:0]        tap_addr;
  logic [ADDR_W-1:0]        next_head;
  logic                     bank_locked;
  logic                     coef_we;
  logic signed [ACC_W:0]    rounded;
  logic signed [DATA_W-1:0] sat_val;
  logic                     clipped;

  // Tap k of the active channel lives at (head - k) mod TAPS.
  always_comb begin
    cur_head = head[cur_chan];
    if (cur_head >= cnt) tap_addr = cur_head - cnt;
    else                 tap_addr = ADDR_W'(TAPS - int'(cnt) + int'(cur_head));
    next_head = (cur_head == LAST_TAP) ? '0 : cur_head + 1'b1;
  end

  always_comb begin
    bank_locked = (bus.coef_wr_bank == cur_bank) &&
                  (state == LOAD || state == MAC || state == DRAIN);
    coef_we     = bus.coef_wr_en && !bank_locked && (int'(bus.coef_wr_addr) < TAPS);
  end

  always_comb begin
    rounded = ((ACC_W+1)'(acc) + HALF) >>> COEF_FRAC;
    sat_val = rounded[DATA_W-1:0];
    clipped = 1'b0;
    if (rounded > MAX_OUT) begin
      sat_val = DATA_W'(MAX_OUT);
      clipped = 1'b1;
    end else if (rounded < MIN_OUT) begin
      sat_val = DATA_W'(MIN_OUT);
      clipped = 1'b1;
    end
  end

  // Storage and the read/multiply pipeline carry no reset; CLEAR scrubs the rings.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int c = 0; c < NCH; c++) hist[c][cnt] <= '0;
    end else if (state == LOAD) begin
      hist[cur_chan][cur_head] <= cur_sample;
    end
    if (coef_we) coef[bus.coef_wr_bank][bus.coef_wr_addr] <= bus.coef_wr_data;
    rd_sample <= hist[cur_chan][tap_addr];
    rd_coef   <= coef[cur_bank][cnt];
    prod      <= rd_sample * rd_coef;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CLEAR;
      cnt             <= '0;
      cur_chan        <= '0;
      cur_bank        <= '0;
      cur_sample      <= '0;
      for (int c = 0; c < NCH; c++) head[c] <= '0;
      rd_vld          <= 1'b0;
      prod_vld        <= 1'b0;
      acc             <= '0;
      bus.filt_result <= '0;
      bus.filt_chan_o <= '0;
      bus.filt_sat    <= 1'b0;
      bus.filt_done   <= 1'b0;
      bus.filt_drop   <= 1'b0;
      bus.filt_busy   <= 1'b1;
    end else begin
      bus.filt_done <= 1'b0;
      bus.filt_drop <= bus.filt_start && (state != IDLE || bus.hist_clr);
      rd_vld        <= (state == MAC);
      prod_vld      <= rd_vld;
      if (prod_vld) acc <= acc + ACC_W'(prod);
      case (state)
        CLEAR: begin
          for (int c = 0; c < NCH; c++) head[c] <= '0;
          if (cnt == LAST_TAP) begin
            cnt           <= '0;
            state         <= IDLE;
            bus.filt_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.hist_clr) begin
            cnt           <= '0;
            state         <= CLEAR;
            bus.filt_busy <= 1'b1;
          end else if (bus.filt_start) begin
            cur_chan      <= bus.filt_chan;
            cur_bank      <= bus.filt_select;
            cur_sample    <= bus.input_val;
            state         <= LOAD;
            bus.filt_busy <= 1'b1;
          end
        end
        LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          state <= MAC;
        end
        MAC: begin
          if (cnt == LAST_TAP) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == ADDR_W'(1)) begin
            cnt   <= '0;
            state <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          bus.filt_result <= sat_val;
          bus.filt_sat    <= clipped;
          bus.filt_chan_o <= cur_chan;
          bus.filt_done   <= 1'b1;
          head[cur_chan]  <= next_head;
          state           <= IDLE;
          bus.filt_busy   <= 1'b0;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
